// File: rtl/de2_115_nios_key_pio_in.sv
// de2_115_nios_key_pio_in: Avalon-MM push-button input port with debounce, edge capture and irq
//   clk, reset_n          : system clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata    : Avalon-MM slave write side (4-word slot)
//   readdata              : combinational read data, zero wait states
//   in_port               : raw asynchronous inputs
//   irq                   : level interrupt, |(EDGECAP & IRQMASK)
module de2_115_nios_key_pio_in #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter bit               EDGE_POLARITY   = 1'b0,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] r_sync1, r_sync2, r_stable, r_mask, r_edgecap;
  logic [WIDTH-1:0] w_done, w_edge, w_clr, w_rd;
  logic             w_wr;
  logic             w_unused;
  assign w_wr     = chipselect && !write_n;
  assign w_unused = ^writedata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_sync1 <= RESET_LEVEL;
      r_sync2 <= RESET_LEVEL;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  // Per-bit counter of consecutive cycles that sync2 disagrees with stable;
  // a return to the stable level clears it, so glitches restart the count.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CW-1:0] r_cnt;
    assign w_done[i] = (r_sync2[i] != r_stable[i]) && (r_cnt == LAST);
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r_cnt <= '0;
      else r_cnt <= (r_sync2[i] == r_stable[i] || r_cnt == LAST) ? '0 : r_cnt + 1'b1;
  end
  // w_done implies sync2 differs from stable, so toggling adopts the new level
  assign w_edge = w_done & (EDGE_POLARITY ? r_sync2 : ~r_sync2);
  assign w_clr  = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_stable  <= RESET_LEVEL;
      r_mask    <= '0;
      r_edgecap <= '0;
    end else begin
      r_stable  <= r_stable ^ w_done;
      r_mask    <= (w_wr && address == 2'd2) ? writedata[WIDTH-1:0] : r_mask;
      // a new edge overrides a same-cycle W1C clear
      r_edgecap <= w_edge | (r_edgecap & ~w_clr);
    end
  always_comb begin
    w_rd = address == 2'd0 ? r_stable : address == 2'd2 ? r_mask : address == 2'd3 ? r_edgecap : '0;
    readdata = '0;
    readdata[WIDTH-1:0] = w_rd;
  end
  assign irq = |(r_edgecap & r_mask);
endmodule

// File: tb/tb_de2_115_nios_key_pio_in.sv
// tb_de2_115_nios_key_pio_in: self-checking bench for the key PIO input port
module tb_de2_115_nios_key_pio_in;
  localparam int D = 4;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  in_port = 4'hF;
  logic        irq;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string       name;
    logic [1:0]  addr;
    logic [31:0] exp;
  } rd_t;
  typedef struct {
    string       name;
    logic        wr;
    logic        cs;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        exp_irq;
  } vec_t;
  rd_t  sb[$];
  vec_t vecs[8];
  de2_115_nios_key_pio_in #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(D),
    .EDGE_POLARITY(1'b0),
    .RESET_LEVEL(4'hF)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .in_port(in_port),
    .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic cs = 1'b1);
    chipselect = cs;
    write_n = 1'b0;
    address = a;
    writedata = d;
    tick();
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = '0;
  endtask
  task automatic expect_rd(input string name, input logic [1:0] a, input logic [31:0] e);
    sb.push_back('{name, a, e});
  endtask
  task automatic drain();
    rd_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      address = e.addr;
      #1;
      checks++;
      if (readdata !== e.exp) begin
        errors++;
        $display("FAIL %s: readdata=0x%08h expected 0x%08h", e.name, readdata, e.exp);
      end
    end
  endtask
  task automatic check_irq(input string name, input logic e);
    checks++;
    if (irq !== e) begin
      errors++;
      $display("FAIL %s: irq=%b expected %b", name, irq, e);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    vecs[0] = '{"tbl_data",      1'b0, 1'b0, 2'd0, 32'h0,        32'hF, 1'b0};
    vecs[1] = '{"tbl_rsv",       1'b0, 1'b0, 2'd1, 32'h0,        32'h0, 1'b0};
    vecs[2] = '{"mask_wr",       1'b1, 1'b1, 2'd2, 32'hFFFFFFF5, 32'h5, 1'b0};
    vecs[3] = '{"data_ro",       1'b1, 1'b1, 2'd0, 32'h0,        32'hF, 1'b0};
    vecs[4] = '{"rsv_wr",        1'b1, 1'b1, 2'd1, 32'hFFFFFFFF, 32'h0, 1'b0};
    vecs[5] = '{"ecap_w1c_idle", 1'b1, 1'b1, 2'd3, 32'hF,        32'h0, 1'b0};
    vecs[6] = '{"mask_clr",      1'b1, 1'b1, 2'd2, 32'h0,        32'h0, 1'b0};
    vecs[7] = '{"mask_no_cs",    1'b1, 1'b0, 2'd2, 32'hF,        32'h0, 1'b0};
    // reset state, read while reset is held
    tick(3);
    expect_rd("rst_data", 2'd0, 32'hF);
    expect_rd("rst_rsv", 2'd1, 32'h0);
    expect_rd("rst_mask", 2'd2, 32'h0);
    expect_rd("rst_ecap", 2'd3, 32'h0);
    drain();
    check_irq("rst_irq", 1'b0);
    reset_n = 1'b1;
    tick();
    // register access table
    for (int i = 0; i < $size(vecs); i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].cs);
      expect_rd(vecs[i].name, vecs[i].addr, vecs[i].exp);
      drain();
      check_irq({vecs[i].name, "_irq"}, vecs[i].exp_irq);
    end
    // glitch of 3 cycles on bit 1 is one short of the debounce length
    in_port[1] = 1'b0;
    tick(3);
    in_port[1] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      expect_rd($sformatf("glitch_data_c%0d", n), 2'd0, 32'hF);
      drain();
    end
    expect_rd("glitch_ecap", 2'd3, 32'h0);
    drain();
    // clean press on bit 0: DATA changes at edge k+5 (6th edge after the drive)
    in_port[0] = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      expect_rd($sformatf("press_data_e%0d", n), 2'd0, n >= 6 ? 32'hE : 32'hF);
      drain();
    end
    expect_rd("press_ecap", 2'd3, 32'h1);
    drain();
    check_irq("press_irq_masked", 1'b0);
    // irq and W1C clear
    bus_write(2'd2, 32'h1);
    check_irq("irq_after_mask", 1'b1);
    bus_write(2'd3, 32'h2);
    check_irq("irq_w1c_other", 1'b1);
    expect_rd("ecap_w1c_other", 2'd3, 32'h1);
    drain();
    bus_write(2'd3, 32'h1);
    expect_rd("ecap_w1c_clear", 2'd3, 32'h0);
    drain();
    check_irq("irq_w1c_clear", 1'b0);
    // set/clear collision: W1C of bit 2 on the edge where stable[2] falls
    in_port[2] = 1'b0;
    tick(5);
    expect_rd("coll_data_before", 2'd0, 32'hE);
    drain();
    bus_write(2'd3, 32'h4);
    expect_rd("coll_data_after", 2'd0, 32'hA);
    expect_rd("coll_ecap", 2'd3, 32'h4);
    drain();
    check_irq("coll_irq_masked", 1'b0);
    // rising edge on bit 0 is not captured
    in_port[0] = 1'b1;
    tick(8);
    expect_rd("rise_data", 2'd0, 32'hB);
    expect_rd("rise_ecap", 2'd3, 32'h4);
    drain();
    bus_write(2'd2, 32'h4);
    check_irq("irq_bit2", 1'b1);
    // reset in the middle of a debounce on bit 3
    in_port[3] = 1'b0;
    tick(4);
    expect_rd("mid_data", 2'd0, 32'hB);
    drain();
    reset_n = 1'b0;
    #1;
    expect_rd("mid_rst_data", 2'd0, 32'hF);
    expect_rd("mid_rst_ecap", 2'd3, 32'h0);
    expect_rd("mid_rst_mask", 2'd2, 32'h0);
    drain();
    check_irq("mid_rst_irq", 1'b0);
    tick();
    reset_n = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      expect_rd($sformatf("rerun_data_e%0d", n), 2'd0, n >= 6 ? 32'h3 : 32'hF);
      drain();
    end
    expect_rd("rerun_ecap", 2'd3, 32'hC);
    drain();
    check_irq("rerun_irq", 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
